alu_seq: RTL and testbench

Parametrised, handshaked RISC-V integer execute unit: the sequential successor to the combinational 64-bit ALU. It covers the full RV base register-register operation set plus the M-extension multiply/divide group, decoded from funct3/funct7 exactly as in the ISA. Operands enter over a valid/ready handshake and results leave over a second one, so the core can stall on multi-cycle multiply/divide. The block sits between register read and writeback.

---
 rtl/alu_seq.sv | 252 +++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked RISC-V integer execute unit (RV base R-type ops plus M extension).
// Base ops complete in one cycle. Multiply/divide iterate one bit per cycle over XLEN cycles.
// Optional feature macro: ALU_SEQ_DIV_EN enables DIV/DIVU/REM/REMU.
// Without the macro, those encodings report err.
module alu_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            err
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic                accept_s;
  logic                last_s;
  logic                is_base_s;
  logic                is_mop_s;
  logic [SW-1:0]       shamt_s;
  logic [XLEN-1:0]     base_res_s;
  logic                sa_s;
  logic                sb_s;
  logic [XLEN-1:0]     a_mag_s;
  logic [XLEN-1:0]     b_mag_s;
  logic [XLEN:0]       mul_sum_s;
  logic [2*XLEN-1:0]   p_next_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     fix_res_s;

  logic [2*XLEN-1:0]   p_r;      // product accumulator, or {remainder, quotient}
  logic [XLEN-1:0]     m_r;      // multiplicand magnitude, or divisor magnitude
  logic [2:0]          f3_r;
  logic                neg_r;    // negate product / quotient at the end
  logic [SW-1:0]       cnt_r;
  logic [XLEN-1:0]     rd_r;
  logic                err_r;
`ifdef ALU_SEQ_DIV_EN
  logic [2*XLEN:0]     div_sh_s;
  logic [XLEN:0]       div_diff_s;
  logic                sa_r;     // dividend sign, sets the remainder sign
  logic                dz_r;     // divide by zero
  logic [XLEN-1:0]     a_raw_r;  // raw dividend, returned as remainder on divide by zero
`endif

  assign rd  = rd_r;
  assign err = err_r;

  // Handshake signals and end-of-iteration detection
  always_comb begin
    in_ready  = (state_r == IDLE) && !rst;
    accept_s  = in_valid && in_ready;
    out_valid = (state_r == DONE);
    last_s    = (state_r == BUSY) && (cnt_r == SW'(XLEN-1));
  end

  // Decode funct7/funct3 into base, multi-cycle, or unsupported
  always_comb begin
    is_base_s = 1'b0;
    is_mop_s  = 1'b0;
    case (funct7)
      7'b0000000: is_base_s = 1'b1;
      7'b0100000: is_base_s = (funct3 == 3'b000) || (funct3 == 3'b101);
      7'b0000001: begin
`ifdef ALU_SEQ_DIV_EN
        is_mop_s = 1'b1;
`else
        is_mop_s = ~funct3[2];
`endif
      end
      default: is_base_s = 1'b0;
    endcase
  end

  // Single-cycle base operation result
  always_comb begin
    shamt_s    = rs2[SW-1:0];
    base_res_s = {XLEN{1'b0}};
    case (funct3)
      3'b000: begin
        if (funct7[5]) base_res_s = rs1 - rs2;
        else           base_res_s = rs1 + rs2;
      end
      3'b001: base_res_s = rs1 << shamt_s;
      3'b010: base_res_s = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      3'b011: base_res_s = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
      3'b100: base_res_s = rs1 ^ rs2;
      3'b101: begin
        if (funct7[5]) base_res_s = $signed(rs1) >>> shamt_s;
        else           base_res_s = rs1 >> shamt_s;
      end
      3'b110: base_res_s = rs1 | rs2;
      3'b111: base_res_s = rs1 & rs2;
      default: base_res_s = {XLEN{1'b0}};
    endcase
  end

  // Operand signs and magnitudes for the iterative unit
  always_comb begin
    sa_s = 1'b0;
    sb_s = 1'b0;
    case (funct3)
      3'b001, 3'b100, 3'b110: begin
        sa_s = rs1[XLEN-1];
        sb_s = rs2[XLEN-1];
      end
      3'b010: begin
        sa_s = rs1[XLEN-1];
        sb_s = 1'b0;
      end
      default: begin
        sa_s = 1'b0;
        sb_s = 1'b0;
      end
    endcase
    if (sa_s) a_mag_s = {XLEN{1'b0}} - rs1;
    else      a_mag_s = rs1;
    if (sb_s) b_mag_s = {XLEN{1'b0}} - rs2;
    else      b_mag_s = rs2;
  end

  // One shift-add (multiply) or restoring-subtract (divide) step
  always_comb begin
    mul_sum_s = {1'b0, p_r[2*XLEN-1:XLEN]} + (p_r[0] ? {1'b0, m_r} : {(XLEN+1){1'b0}});
    p_next_s  = {mul_sum_s, p_r[XLEN-1:1]};
`ifdef ALU_SEQ_DIV_EN
    div_sh_s   = {p_r, 1'b0};
    div_diff_s = div_sh_s[2*XLEN:XLEN] - {1'b0, m_r};
    if (f3_r[2]) begin
      if (!div_diff_s[XLEN]) p_next_s = {div_diff_s[XLEN-1:0], div_sh_s[XLEN-1:1], 1'b1};
      else                   p_next_s = div_sh_s[2*XLEN-1:0];
    end else begin
      p_next_s = {mul_sum_s, p_r[XLEN-1:1]};
    end
`endif
  end

  // Final-cycle sign fix-up and result selection; overflow (MIN / -1) falls out naturally
  always_comb begin
    if (neg_r) prod_s = {(2*XLEN){1'b0}} - p_next_s;
    else       prod_s = p_next_s;
    fix_res_s = {XLEN{1'b0}};
    case (f3_r)
      3'b000:                 fix_res_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res_s = prod_s[2*XLEN-1:XLEN];
`ifdef ALU_SEQ_DIV_EN
      3'b100: begin
        if (dz_r)       fix_res_s = {XLEN{1'b1}};
        else if (neg_r) fix_res_s = {XLEN{1'b0}} - p_next_s[XLEN-1:0];
        else            fix_res_s = p_next_s[XLEN-1:0];
      end
      3'b101: begin
        if (dz_r) fix_res_s = {XLEN{1'b1}};
        else      fix_res_s = p_next_s[XLEN-1:0];
      end
      3'b110: begin
        if (dz_r)      fix_res_s = a_raw_r;
        else if (sa_r) fix_res_s = {XLEN{1'b0}} - p_next_s[2*XLEN-1:XLEN];
        else           fix_res_s = p_next_s[2*XLEN-1:XLEN];
      end
      3'b111: begin
        if (dz_r) fix_res_s = a_raw_r;
        else      fix_res_s = p_next_s[2*XLEN-1:XLEN];
      end
`endif
      default: fix_res_s = {XLEN{1'b0}};
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = is_mop_s ? BUSY : DONE;
        else          state_next_s = IDLE;
      end
      BUSY: begin
        if (last_s) state_next_s = DONE;
        else        state_next_s = BUSY;
      end
      DONE: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_r     <= {(2*XLEN){1'b0}};
      m_r     <= {XLEN{1'b0}};
      f3_r    <= 3'b000;
      neg_r   <= 1'b0;
      cnt_r   <= {SW{1'b0}};
      rd_r    <= {XLEN{1'b0}};
      err_r   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      sa_r    <= 1'b0;
      dz_r    <= 1'b0;
      a_raw_r <= {XLEN{1'b0}};
`endif
    end else if (accept_s) begin
      f3_r  <= funct3;
      neg_r <= sa_s ^ sb_s;
      cnt_r <= {SW{1'b0}};
      rd_r  <= is_base_s ? base_res_s : {XLEN{1'b0}};
      err_r <= ~(is_base_s | is_mop_s);
      if (funct3[2]) begin
        p_r <= {{XLEN{1'b0}}, a_mag_s};
        m_r <= b_mag_s;
      end else begin
        p_r <= {{XLEN{1'b0}}, b_mag_s};
        m_r <= a_mag_s;
      end
`ifdef ALU_SEQ_DIV_EN
      sa_r    <= sa_s;
      dz_r    <= (rs2 == {XLEN{1'b0}});
      a_raw_r <= rs1;
`endif
    end else if (state_r == BUSY) begin
      p_r   <= p_next_s;
      cnt_r <= cnt_r + SW'(1'b1);
      if (last_s) rd_r <= fix_res_s;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized bench for alu_seq (XLEN = 64).
// Expected results come from a plain-arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'd0;
  logic [63:0] rs1 = 64'd0;
  logic [63:0] rs2 = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] rd;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
`ifdef ALU_SEQ_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  alu_seq #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model straight from the ISA rules
  task automatic ref_model(input logic [6:0] f7, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] r, output logic e, output int lat);
    logic [127:0] ax, bx, pr;
    r = 64'd0; e = 1'b0; lat = 1;
    if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
      case (f3)
        3'd0: r = (f7 == 7'h20) ? a - b : a + b;
        3'd1: r = a << b[5:0];
        3'd2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        3'd3: r = (a < b) ? 64'd1 : 64'd0;
        3'd4: r = a ^ b;
        3'd5: begin
          if (f7 == 7'h20) r = $signed(a) >>> b[5:0];
          else             r = a >> b[5:0];
        end
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else if (f7 == 7'h01 && (DIV_ON || f3 < 3'd4)) begin
      lat = 65;
      ax = {64'd0, a};
      bx = {64'd0, b};
      if (f3 == 3'd1 || f3 == 3'd2) ax = {{64{a[63]}}, a};
      if (f3 == 3'd1) bx = {{64{b[63]}}, b};
      pr = ax * bx;
      case (f3)
        3'd0: r = pr[63:0];
        3'd1, 3'd2, 3'd3: r = pr[127:64];
        3'd4: begin
          if (b == 64'd0)                   r = ONES;
          else if (a == MINV && b == ONES)  r = MINV;
          else                              r = $signed(a) / $signed(b);
        end
        3'd5: begin
          if (b == 64'd0) r = ONES;
          else            r = a / b;
        end
        3'd6: begin
          if (b == 64'd0)                   r = a;
          else if (a == MINV && b == ONES)  r = 64'd0;
          else                              r = $signed(a) % $signed(b);
        end
        default: begin
          if (b == 64'd0) r = a;
          else            r = a % b;
        end
      endcase
    end else begin
      e = 1'b1;
    end
  endtask

  // One full transaction: accept, wait for result, hold backpressure, handshake
  task automatic do_op(input logic [6:0] f7, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_rd, input logic exp_err,
                       input int exp_lat, input int hold);
    int lat;
    logic busy_rdy;
    @(negedge clk);
    check_eq("idle_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; funct7 = f7; funct3 = f3; rs1 = a; rs2 = b;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    funct7 = 7'($urandom); funct3 = 3'($urandom);
    rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
    lat = 1; busy_rdy = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_rdy = 1'b1;
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("busy_ready", 64'(busy_rdy), 64'd0);
    check_eq("rd", rd, exp_rd);
    check_eq("err", 64'(err), 64'(exp_err));
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'($urandom);
      funct7 = 7'h00; funct3 = 3'($urandom);
      rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
      @(negedge clk);
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_ready", 64'(in_ready), 64'd0);
      check_eq("hold_rd", rd, exp_rd);
      check_eq("hold_err", 64'(err), 64'(exp_err));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("post_ready", 64'(in_ready), 64'd1);
    check_eq("post_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return ONES;
      3: return MINV;
      4: return MAXV;
      5: return 64'($signed($urandom_range(0, 40)) - 20);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  typedef struct {
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic        e;
    int          lat;
  } vec_t;

  vec_t dir[$];

  initial begin
    logic [63:0] mr;
    logic        me;
    int          ml;
    logic        seen;
    int          sel;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [63:0] a, b;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 64'(in_ready), 64'd0);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_rd", rd, 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    rst = 1'b0;

    // Directed vectors with literal expectations
    dir.push_back('{7'h00, 3'd0, 64'h8000_0000_0000_0001, 64'd1, 64'h8000_0000_0000_0002, 1'b0, 1});
    dir.push_back('{7'h20, 3'd0, 64'd1, 64'd5, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1});
    dir.push_back('{7'h20, 3'd5, ONES, 64'd4, ONES, 1'b0, 1});
    dir.push_back('{7'h00, 3'd5, 64'h10, 64'd2, 64'h4, 1'b0, 1});
    dir.push_back('{7'h00, 3'd1, 64'h3, 64'h44, 64'h30, 1'b0, 1});
    dir.push_back('{7'h00, 3'd2, MAXV, 64'd1, 64'd0, 1'b0, 1});
    dir.push_back('{7'h00, 3'd2, ONES, 64'd1, 64'd1, 1'b0, 1});
    dir.push_back('{7'h00, 3'd3, ONES, 64'd1, 64'd0, 1'b0, 1});
    dir.push_back('{7'h01, 3'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 65});
    dir.push_back('{7'h01, 3'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65});
    dir.push_back('{7'h01, 3'd1, ONES, ONES, 64'd0, 1'b0, 65});
    dir.push_back('{7'h01, 3'd2, ONES, 64'd2, ONES, 1'b0, 65});
    dir.push_back('{7'h03, 3'd0, 64'd9, 64'd9, 64'd0, 1'b1, 1});
    dir.push_back('{7'h20, 3'd1, 64'd9, 64'd1, 64'd0, 1'b1, 1});
`ifdef ALU_SEQ_DIV_EN
    dir.push_back('{7'h01, 3'd4, 64'd7, 64'd0, ONES, 1'b0, 65});
    dir.push_back('{7'h01, 3'd6, 64'd7, 64'd0, 64'd7, 1'b0, 65});
    dir.push_back('{7'h01, 3'd4, MINV, ONES, MINV, 1'b0, 65});
    dir.push_back('{7'h01, 3'd6, MINV, ONES, 64'd0, 1'b0, 65});
    dir.push_back('{7'h01, 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65});
    dir.push_back('{7'h01, 3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 1'b0, 65});
    dir.push_back('{7'h01, 3'd5, 64'd100, 64'd7, 64'd14, 1'b0, 65});
    dir.push_back('{7'h01, 3'd7, 64'd100, 64'd7, 64'd2, 1'b0, 65});
`else
    dir.push_back('{7'h01, 3'd4, 64'd7, 64'd2, 64'd0, 1'b1, 1});
    dir.push_back('{7'h01, 3'd7, 64'd7, 64'd2, 64'd0, 1'b1, 1});
`endif
    foreach (dir[i]) begin
      do_op(dir[i].f7, dir[i].f3, dir[i].a, dir[i].b, dir[i].r, dir[i].e, dir[i].lat,
            (i % 3 == 0) ? 5 : 0);
    end

    // Reset during BUSY of a MUL aborts it
    @(negedge clk);
    in_valid = 1'b1; funct7 = 7'h01; funct3 = 3'd0; rs1 = 64'd12345; rs2 = 64'd678;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("busy_ready_mid", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    check_eq("abort_valid", 64'(out_valid), 64'd0);
    check_eq("abort_rd", rd, 64'd0);
    check_eq("abort_err", 64'(err), 64'd0);
    check_eq("abort_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_idle", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("abort_no_result", 64'(seen), 64'd0);
    do_op(7'h00, 3'd0, 64'd2, 64'd3, 64'd5, 1'b0, 1, 0);

    // Reset while holding a result in DONE clears rd/err at once
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b0;
      funct7 = (j == 0) ? 7'h00 : 7'h7F; funct3 = 3'd4;
      rs1 = 64'hA5A5_0000_1234_5678; rs2 = 64'd0;
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("done_valid", 64'(out_valid), 64'd1);
      check_eq("done_rd", rd, (j == 0) ? 64'hA5A5_0000_1234_5678 : 64'd0);
      check_eq("done_err", 64'(err), 64'(j));
      rst = 1'b1;
      #1;
      check_eq("drst_valid", 64'(out_valid), 64'd0);
      check_eq("drst_rd", rd, 64'd0);
      check_eq("drst_err", 64'(err), 64'd0);
      @(negedge clk);
      rst = 1'b0;
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      f7 = 7'h00;
      else if (sel < 6) f7 = 7'h20;
      else if (sel < 9) f7 = 7'h01;
      else              f7 = 7'($urandom);
      f3 = 3'($urandom);
      a = pick();
      b = pick();
      ref_model(f7, f3, a, b, mr, me, ml);
      do_op(f7, f3, a, b, mr, me, ml, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
